// File: rtl/dmem_responder.sv
// dmem_responder: latency-programmable word/block data memory answering the core's data port
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic         dBlkRead,
  input  logic         dBlkWrite,
  input  logic [31:0]  data_address_2DM,
  input  logic [31:0]  data_write_2DM,
  input  logic [255:0] block_write_2DM,
  output logic [31:0]  data_read_fDM,
  output logic [255:0] block_read_fDM,
  output logic         mem_busy,
  output logic         mem_done
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_BRD, OP_BWR} op_t;
  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d, rdata_q, rdata_d;
  logic [255:0]   bwdata_q, bwdata_d, brdata_q, brdata_d;
  logic           done_q, done_d;
  logic           req, fire;
  logic           unused_addr_bits;
  logic [31:0]    mem [DEPTH_WORDS];
  assign req  = MemRead | MemWrite | dBlkRead | dBlkWrite;
  assign fire = state_q == WAIT && cnt_q == 8'd0;
  // Only the word index survives the wrap; the byte offset and high bits are dropped.
  assign unused_addr_bits = ^{data_address_2DM[31:AW+2], data_address_2DM[1:0]};
  assign mem_busy       = (state_q == IDLE && req) || state_q == WAIT;
  assign mem_done       = done_q;
  assign data_read_fDM  = rdata_q;
  assign block_read_fDM = brdata_q;
  // Next state: latch the winning request in IDLE, count down in WAIT, perform reads at the last WAIT edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bwdata_d = bwdata_q;
    rdata_d  = rdata_q;
    brdata_d = brdata_q;
    done_d   = fire;
    if (state_q == IDLE && req) begin
      state_d  = WAIT;
      cnt_d    = 8'(LATENCY - 1);
      op_d     = dBlkWrite ? OP_BWR : dBlkRead ? OP_BRD : MemWrite ? OP_WR : OP_RD;
      addr_d   = data_address_2DM[AW+1:2];
      wdata_d  = data_write_2DM;
      bwdata_d = block_write_2DM;
    end
    if (state_q == WAIT) begin
      cnt_d   = cnt_q - 8'd1;
      state_d = fire ? DONE : WAIT;
    end
    if (state_q == DONE) state_d = IDLE;
    if (fire && op_q == OP_RD) rdata_d = mem[addr_q];
    if (fire && op_q == OP_BRD)
      for (int i = 0; i < 8; i++) brdata_d[32*i +: 32] = mem[{addr_q[AW-1:3], 3'(i)}];
  end
  // Control and response registers; reset aborts any access in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      rdata_q  <= 32'd0;
      brdata_q <= 256'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      brdata_q <= brdata_d;
      done_q   <= done_d;
    end
    op_q     <= op_d;
    addr_q   <= addr_d;
    wdata_q  <= wdata_d;
    bwdata_q <= bwdata_d;
  end
  // Storage: writes commit at the WAIT->DONE edge unless reset cancels them.
  always_ff @(posedge CLK) begin
    if (!RESET && fire && op_q == OP_WR) mem[addr_q] <= wdata_q;
    if (!RESET && fire && op_q == OP_BWR)
      for (int i = 0; i < 8; i++) mem[{addr_q[AW-1:3], 3'(i)}] <= bwdata_q[32*i +: 32];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a memory-array model
module tb_dmem_responder;
  localparam int LAT = 4, DEPTH = 1024;
  logic         CLK = 0, RESET = 1;
  logic         MemRead = 0, MemWrite = 0, dBlkRead = 0, dBlkWrite = 0;
  logic [31:0]  addr = 0, wd = 0;
  logic [255:0] bwd = 0;
  logic [31:0]  data_read_fDM;
  logic [255:0] block_read_fDM;
  logic         mem_busy, mem_done;
  int           checks = 0, failures = 0;
  logic [31:0]  ref_mem [DEPTH];
  logic [31:0]  exp_rd = 0;
  logic [255:0] exp_brd = 0;
  logic [255:0] b;
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .MemRead(MemRead), .MemWrite(MemWrite),
    .dBlkRead(dBlkRead), .dBlkWrite(dBlkWrite), .data_address_2DM(addr),
    .data_write_2DM(wd), .block_write_2DM(bwd), .data_read_fDM(data_read_fDM),
    .block_read_fDM(block_read_fDM), .mem_busy(mem_busy), .mem_done(mem_done)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int unsigned wi(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction
  function automatic int unsigned bb(input logic [31:0] a);
    return ((a / 32) * 8) % DEPTH;
  endfunction
  task automatic model(input int kind, input logic [31:0] a, input logic [31:0] w, input logic [255:0] bw);
    if (kind == 0) exp_rd = ref_mem[wi(a)];
    if (kind == 1) ref_mem[wi(a)] = w;
    if (kind == 2) for (int i = 0; i < 8; i++) exp_brd[32*i +: 32] = ref_mem[bb(a) + i];
    if (kind == 3) for (int i = 0; i < 8; i++) ref_mem[bb(a) + i] = bw[32*i +: 32];
  endtask
  task automatic set_req(input int kind, input logic v);
    MemRead   = v && kind == 0;
    MemWrite  = v && kind == 1;
    dBlkRead  = v && kind == 2;
    dBlkWrite = v && kind == 3;
  endtask
  task automatic rand_block(output logic [255:0] r);
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
  endtask
  task automatic scramble();
    addr = $urandom;
    wd   = $urandom;
    rand_block(bwd);
  endtask
  task automatic finish_op(input string tag);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge CLK);
      chk({tag, "_wait_busy"}, 256'(mem_busy), 256'(1));
      chk({tag, "_wait_done"}, 256'(mem_done), 256'(0));
    end
    @(negedge CLK);
    chk({tag, "_done_busy"}, 256'(mem_busy), 256'(0));
    chk({tag, "_done_pulse"}, 256'(mem_done), 256'(1));
  endtask
  task automatic op(input int kind, input logic [31:0] a, input logic [31:0] w, input logic [255:0] bw, input string tag);
    @(negedge CLK);
    addr = a; wd = w; bwd = bw;
    set_req(kind, 1'b1);
    #1 chk({tag, "_req_busy"}, 256'(mem_busy), 256'(1));
    @(posedge CLK);
    #1 set_req(kind, 1'b0);
    scramble();
    finish_op(tag);
    model(kind, a, w, bw);
    chk({tag, "_rd"}, 256'(data_read_fDM), 256'(exp_rd));
    chk({tag, "_brd"}, block_read_fDM, exp_brd);
  endtask
  initial begin
    repeat (2) @(posedge CLK);
    #1 RESET = 0;
    @(negedge CLK);
    chk("rst_busy", 256'(mem_busy), 256'(0));
    chk("rst_done", 256'(mem_done), 256'(0));
    chk("rst_rd", 256'(data_read_fDM), 256'(0));
    chk("rst_brd", block_read_fDM, 256'(0));
    for (int k = 0; k < DEPTH / 8; k++) begin
      rand_block(b);
      op(3, 32'(k * 32), 32'd0, b, "init");
    end
    op(1, 32'h40, 32'hDEADBEEF, 256'd0, "t2_wr");
    op(0, 32'h43, 32'd0, 256'd0, "t2_rd");
    chk("t2_value", 256'(data_read_fDM), 256'(32'hDEADBEEF));
    for (int i = 0; i < 8; i++) b[32*i +: 32] = 32'h11111111 * 32'(i + 1);
    op(3, 32'h100, 32'd0, b, "t3_bwr");
    op(0, 32'h10C, 32'd0, 256'd0, "t3_rd");
    chk("t3_word3", 256'(data_read_fDM), 256'(32'h44444444));
    op(2, 32'h11F, 32'd0, 256'd0, "t3_brd");
    chk("t3_block", block_read_fDM, b);
    rand_block(b);
    @(negedge CLK);
    addr = 32'h40; bwd = b; MemRead = 1; dBlkWrite = 1;
    #1 chk("t4_req_busy", 256'(mem_busy), 256'(1));
    @(posedge CLK);
    #1 dBlkWrite = 0;
    finish_op("t4_bwr");
    model(3, 32'h40, 32'd0, b);
    chk("t4_rd_kept", 256'(data_read_fDM), 256'(exp_rd));
    @(negedge CLK);
    chk("t4_idle_busy", 256'(mem_busy), 256'(1));
    @(posedge CLK);
    #1 MemRead = 0;
    scramble();
    finish_op("t4_rd");
    model(0, 32'h40, 32'd0, 256'd0);
    chk("t4_word0", 256'(data_read_fDM), 256'(b[31:0]));
    @(negedge CLK);
    addr = 32'h80; wd = 32'h12345678; MemWrite = 1;
    @(posedge CLK);
    #1 MemWrite = 0;
    @(negedge CLK);
    chk("t5_w1_done", 256'(mem_done), 256'(0));
    @(negedge CLK);
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      chk("t5_no_done", 256'(mem_done), 256'(0));
      chk("t5_idle", 256'(mem_busy), 256'(0));
      @(negedge CLK);
    end
    exp_rd = 0; exp_brd = 0;
    chk("t5_rst_rd", 256'(data_read_fDM), 256'(0));
    chk("t5_rst_brd", block_read_fDM, 256'(0));
    op(0, 32'h80, 32'd0, 256'd0, "t5_rd");
    op(1, 32'h1000, 32'hA5A5A5A5, 256'd0, "t6_wr");
    op(0, 32'h0, 32'd0, 256'd0, "t6_rd");
    chk("t6_wrap", 256'(data_read_fDM), 256'(32'hA5A5A5A5));
    for (int n = 0; n < 200; n++) begin
      rand_block(b);
      op(int'($urandom_range(0, 3)), $urandom, $urandom, b, "rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
